simon_turn_arbiter: RTL

- Shares one Simon datapath/control core between two players in the two-player memory game.
- Owns whose turn it is, forwards only the active player's pattern entries to the core with a valid/ready handshake, and enforces a per-entry timeout.
- Keeps per-player round scores and declares the winner.
- Sits between the board switch/button debouncers and the Simon top level.

---
 rtl/simon_pkg.sv | 26 ++
 rtl/simon_turn_arbiter_if.sv | 26 ++
 rtl/simon_turn_timer.sv | 30 +++
 rtl/simon_turn_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and constants for the two-player Simon turn arbiter.
// State codes are plain constants so older blocks can still compare them as raw bits.
package simon_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_PLAY      = 2'd1;
    localparam state_t ST_GAME_OVER = 2'd2;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P0   = 2'b01,
        WIN_P1   = 2'b10,
        WIN_TIE  = 2'b11
    } winner_e;

    localparam logic PLAYER0 = 1'b0;
    localparam logic PLAYER1 = 1'b1;

    // When the active player fails, the opponent takes the game.
    function automatic logic [1:0] other_player_wins(input logic player);
        return (player == PLAYER1) ? WIN_P0 : WIN_P1;
    endfunction

endpackage

// File: rtl/simon_turn_arbiter_if.sv
// Pattern handshake and result pulses between the turn arbiter and the Simon core.
interface simon_turn_arbiter_if;

    logic [3:0] core_pattern;
    logic       core_valid;
    logic       core_ready;
    logic       core_round_done;
    logic       core_wrong;

    modport master (
        output core_pattern,
        output core_valid,
        input  core_ready,
        input  core_round_done,
        input  core_wrong
    );

    modport slave (
        input  core_pattern,
        input  core_valid,
        output core_ready,
        output core_round_done,
        output core_wrong
    );

endinterface

// File: rtl/simon_turn_timer.sv
// Per-entry idle timer: counts enabled cycles and flags the TIMEOUT-th one.
// The terminal flag is combinational so the arbiter can act on the same edge.
module simon_turn_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic pclk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    assign expired = count_en && (cnt == LAST);

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= expired ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/simon_turn_arbiter.sv
// Two-player turn arbiter in front of a shared Simon core: forwards the active
// player's entries, times out idle players, keeps scores and picks the winner.
// Optional strike mode (one forgiven failure per player) under SIMON_STRIKES_EN.
module simon_turn_arbiter
    import simon_pkg::*;
#(
    parameter int SCORE_W    = 4,
    parameter int TIMEOUT    = 1000,
    parameter int MAX_ROUNDS = 15
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         p0_pattern,
    input  logic               p0_req,
    input  logic [3:0]         p1_pattern,
    input  logic               p1_req,
    simon_turn_arbiter_if.master core,
    output logic               active_player,
    output logic [SCORE_W-1:0] p0_score,
    output logic [SCORE_W-1:0] p1_score,
    output logic [1:0]         winner,
`ifdef SIMON_STRIKES_EN
    output logic               p0_strike,
    output logic               p1_strike,
`endif
    output logic               game_over
);

    localparam int RW = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS + 1) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t               state;
    logic                 pending;
    logic [3:0]           pend_pattern;
    logic [RW-1:0]        round_cnt;
    logic                 valid_q;
    logic [3:0]           pattern_q;

    logic                 in_play;
    logic                 act_req;
    logic [3:0]           act_pattern;
    logic                 fail;
    logic                 round_ok;
    logic                 quiet;
    logic                 drain;
    logic                 accept;
    logic                 swap_on_fail;
    logic                 end_on_fail;
    logic                 turn_swap;
    logic                 last_round;
    logic                 timer_clear;
    logic                 timer_count;
    logic                 timer_expired;
    logic [SCORE_W-1:0]   p0_next;
    logic [SCORE_W-1:0]   p1_next;
    logic [1:0]           score_winner;

    assign in_play     = (state == ST_PLAY);
    assign game_over   = (state == ST_GAME_OVER);
    assign act_req     = (active_player == PLAYER1) ? p1_req : p0_req;
    assign act_pattern = (active_player == PLAYER1) ? p1_pattern : p0_pattern;

    // Event priority: failure beats a completed round, which beats any entry traffic.
    assign fail     = in_play && (core.core_wrong || timer_expired);
    assign round_ok = in_play && core.core_round_done && !fail;
    assign quiet    = in_play && !fail && !round_ok;
    assign drain    = quiet && pending && core.core_ready;
    assign accept   = quiet && act_req && !pending;

`ifdef SIMON_STRIKES_EN
    logic strike_active;
    assign strike_active = (active_player == PLAYER1) ? p1_strike : p0_strike;
    assign swap_on_fail  = fail && !strike_active;
`else
    assign swap_on_fail  = 1'b0;
`endif

    assign end_on_fail = fail && !swap_on_fail;
    assign turn_swap   = round_ok || swap_on_fail;
    assign last_round  = round_ok && (round_cnt == RW'(MAX_ROUNDS - 1));

    assign timer_clear = !in_play || accept || turn_swap;
    assign timer_count = in_play && core.core_ready && !pending;

    simon_turn_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .pclk     (pclk),
        .rst      (rst),
        .clear    (timer_clear),
        .count_en (timer_count),
        .expired  (timer_expired)
    );

    // Scores after this cycle, so the final-round winner sees the last point.
    always_comb begin
        p0_next = p0_score;
        p1_next = p1_score;
        if (round_ok) begin
            if (active_player == PLAYER0) begin
                if (p0_score != SCORE_MAX) p0_next = p0_score + SCORE_W'(1);
            end else begin
                if (p1_score != SCORE_MAX) p1_next = p1_score + SCORE_W'(1);
            end
        end
    end

    always_comb begin
        score_winner = WIN_TIE;
        if (p0_next > p1_next) begin
            score_winner = WIN_P0;
        end else if (p1_next > p0_next) begin
            score_winner = WIN_P1;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            pending       <= 1'b0;
            pend_pattern  <= '0;
            round_cnt     <= '0;
            valid_q       <= 1'b0;
            pattern_q     <= '0;
            active_player <= PLAYER0;
            p0_score      <= '0;
            p1_score      <= '0;
            winner        <= WIN_NONE;
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start) begin
                        state         <= ST_PLAY;
                        pending       <= 1'b0;
                        round_cnt     <= '0;
                        active_player <= PLAYER0;
                        p0_score      <= '0;
                        p1_score      <= '0;
                        winner        <= WIN_NONE;
                    end
                end
                ST_PLAY: begin
                    p0_score <= p0_next;
                    p1_score <= p1_next;
                    if (end_on_fail) begin
                        state   <= ST_GAME_OVER;
                        winner  <= other_player_wins(active_player);
                        pending <= 1'b0;
                    end else if (turn_swap) begin
                        active_player <= ~active_player;
                        pending       <= 1'b0;
                        if (round_ok) round_cnt <= round_cnt + RW'(1);
                        if (last_round) begin
                            state  <= ST_GAME_OVER;
                            winner <= score_winner;
                        end
                    end else if (drain) begin
                        valid_q   <= 1'b1;
                        pattern_q <= pend_pattern;
                        pending   <= 1'b0;
                    end else if (accept) begin
                        // An idle, ready core takes the entry straight away; otherwise it waits.
                        if (core.core_ready) begin
                            valid_q   <= 1'b1;
                            pattern_q <= act_pattern;
                        end else begin
                            pending      <= 1'b1;
                            pend_pattern <= act_pattern;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SIMON_STRIKES_EN
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            p0_strike <= 1'b0;
            p1_strike <= 1'b0;
        end else if (!in_play && start) begin
            p0_strike <= 1'b0;
            p1_strike <= 1'b0;
        end else if (swap_on_fail) begin
            if (active_player == PLAYER0) p0_strike <= 1'b1;
            else                          p1_strike <= 1'b1;
        end
    end
`endif

    assign core.core_valid   = valid_q;
    assign core.core_pattern = pattern_q;

endmodule
